// File: rtl/sync_fifo_pkg.sv
// Shared sizing constants and word/pointer types for the 16x8 synchronous FIFO.
package sync_fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR_WIDTH = 4;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;
  typedef logic [FIFO_ADDR_WIDTH:0]   fifo_ptr_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and a registered,
// enabled read port. The array itself is never cleared; only the read register resets.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register holds its value unless a read is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, flag decode and accept qualification;
// storage lives in sync_fifo_mem.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  fifo_clk_i,
  input  logic                  fifo_rst_i,
  input  logic                  fifo_wr_en_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_full_o,
  input  logic                  fifo_rd_en_i,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  fifo_empty_o
);
  logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr;
  logic                w_full, w_empty, w_wr_acc, w_rd_acc;

  // Pointers carry an extra wrap bit so equal indices distinguish full from empty.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_wr_acc = fifo_wr_en_i && !w_full  && !fifo_rst_i;
  assign w_rd_acc = fifo_rd_en_i && !w_empty && !fifo_rst_i;

  always_ff @(posedge fifo_clk_i) begin
    if (fifo_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk     (fifo_clk_i),
    .i_rst     (fifo_rst_i),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data (fifo_data_i),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (fifo_data_o)
  );

  assign fifo_full_o  = w_full;
  assign fifo_empty_o = w_empty;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard for ordering and flags.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  fifo_word_t din, dout;
  logic       full, empty;

  int         n_vec = 0;
  int         n_err = 0;
  fifo_word_t q[$];
  fifo_word_t exp_dout;

  sync_fifo dut (
    .fifo_clk_i   (clk),
    .fifo_rst_i   (rst),
    .fifo_wr_en_i (wr_en),
    .fifo_data_i  (din),
    .fifo_full_o  (full),
    .fifo_rd_en_i (rd_en),
    .fifo_data_o  (dout),
    .fifo_empty_o (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; scoreboard judges accepts on pre-edge occupancy.
  task automatic step(input logic w, input logic r, input fifo_word_t d);
    bit full_m, empty_m;
    full_m  = (q.size() == 16);
    empty_m = (q.size() == 0);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (r && !empty_m) exp_dout = q.pop_front();
    if (w && !full_m)  q.push_back(d);
    chk("dout",  dout,  exp_dout);
    chk("empty", {7'd0, empty}, {7'd0, q.size() == 0});
    chk("full",  {7'd0, full},  {7'd0, q.size() == 16});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_dout = 8'h00;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00; exp_dout = 8'h00;
    // Inputs held high during reset must be ignored.
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hFF;
    do_reset();
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full",  {7'd0, full},  8'h00);
    chk("rst_dout",  dout,          8'h00);

    // Single word round trip, then underrun.
    step(1'b1, 1'b0, 8'h64);
    chk("one_empty", {7'd0, empty}, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("one_dout", dout, 8'h64);
    chk("one_drained", {7'd0, empty}, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    chk("underrun_dout", dout, 8'h64);
    step(1'b1, 1'b0, 8'h11);
    step(1'b0, 1'b1, 8'h00);
    chk("after_underrun", dout, 8'h11);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    chk("fill_full", {7'd0, full}, 8'h01);
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_full", {7'd0, full}, 8'h01);
    // Full with both requests: only the read goes through.
    step(1'b1, 1'b1, 8'hEE);
    chk("full_rw_notfull", {7'd0, full}, 8'h00);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", {7'd0, empty}, 8'h01);

    // Concurrent read/write with one word in flight.
    step(1'b1, 1'b0, 8'h78);
    step(1'b1, 1'b1, 8'h01);
    chk("conc_first", dout, 8'h78);
    for (int i = 2; i <= 5; i++) step(1'b1, 1'b1, 8'(i));
    step(1'b0, 1'b1, 8'h00);
    chk("conc_last", dout, 8'h05);
    chk("conc_empty", {7'd0, empty}, 8'h01);

    // Empty with both requests: write lands, no bypass to the output.
    step(1'b1, 1'b1, 8'h5A);
    chk("empty_rw_nobypass", dout, 8'h05);
    step(1'b0, 1'b1, 8'h00);
    chk("empty_rw_read", dout, 8'h5A);

    // Pointer wrap with interleaved pairs.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 8'(8'h80 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("wrap_last", dout, 8'hA7);

    // Reset with entries held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    do_reset();
    chk("mid_rst_empty", {7'd0, empty}, 8'h01);
    chk("mid_rst_full",  {7'd0, full},  8'h00);
    chk("mid_rst_dout",  dout,          8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("mid_rst_underrun", dout, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
